// File: rtl/host_tx_descriptor_arbiter.sv
// Weighted round-robin arbiter sharing the host-tx descriptor path between the HCP and network ports.
// Optional statistics outputs are built when TX_ARB_STATS_EN is defined.
module host_tx_descriptor_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int WEIGHT_W   = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [47:0]         iv_tsntag_hcp,
  input  logic [8:0]          iv_bufid_hcp,
  input  logic                i_inverse_map_lookup_flag_hcp,
  input  logic                i_descriptor_wr_hcp,
  output logic                o_descriptor_ack_hcp,
  input  logic [47:0]         iv_tsntag_network,
  input  logic [8:0]          iv_bufid_network,
  input  logic                i_inverse_map_lookup_flag_network,
  input  logic                i_descriptor_wr_network,
  output logic                o_descriptor_ack_network,
  input  logic [WEIGHT_W-1:0] iv_weight_hcp,
  input  logic [WEIGHT_W-1:0] iv_weight_network,
  output logic [23:0]         ov_descriptor,
  output logic                o_descriptor_wr,
  input  logic                i_descriptor_ready,
  output logic [1:0]          ov_arb_state
`ifdef TX_ARB_STATS_EN
  ,
  output logic [15:0]         ov_grant_cnt_hcp,
  output logic [15:0]         ov_grant_cnt_network,
  output logic                o_fifo_full_pulse_hcp,
  output logic                o_fifo_full_pulse_network
`endif
);

  // Handshakes: a source holds wr (level) until it sees the one-cycle ack, which
  // follows the capture edge; downstream takes a descriptor on any cycle where
  // o_descriptor_wr is high, and a grant is only made while i_descriptor_ready=1.
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_HCP = 2'd1,
    SERVE_NET = 2'd2
  } arb_state_e;

  // Index 0 is the HCP source, index 1 the network source.
  logic [23:0]         in_desc [2];
  logic [1:0]          req, full, empty, push, pop;
  logic [1:0]          ack_q, ack_d;
  logic [AW:0]         cnt_q [2], cnt_d [2];
  logic [AW-1:0]       wr_ptr_q [2], wr_ptr_d [2];
  logic [AW-1:0]       rd_ptr_q [2], rd_ptr_d [2];
  logic [23:0]         mem_q [2][FIFO_DEPTH], mem_d [2][FIFO_DEPTH];
  arb_state_e          state_q, state_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [WEIGHT_W:0]   eff_w [2];
  logic [WEIGHT_W:0]   credit_inc;
  logic [23:0]         desc_q, desc_d;
  logic                dwr_q, dwr_d;
  logic                cur, oth, turn_end;
  logic                unused_tag_bits;

  assign unused_tag_bits = ^{iv_tsntag_hcp[33:0], iv_tsntag_network[33:0]};

  always_comb begin
    in_desc[0] = {i_inverse_map_lookup_flag_hcp, iv_tsntag_hcp[47:34], iv_bufid_hcp};
    in_desc[1] = {i_inverse_map_lookup_flag_network, iv_tsntag_network[47:34], iv_bufid_network};
    req = {i_descriptor_wr_network, i_descriptor_wr_hcp};
    full = '0;
    empty = '0;
    push = '0;
    for (int s = 0; s < 2; s++) begin
      full[s]  = (cnt_q[s] == (AW+1)'(FIFO_DEPTH));
      empty[s] = (cnt_q[s] == '0);
      push[s]  = req[s] & ~full[s] & ~ack_q[s];
    end
    ack_d = push;
  end

  always_comb begin
    eff_w[0]   = (iv_weight_hcp == '0) ? (WEIGHT_W+1)'(1) : {1'b0, iv_weight_hcp};
    eff_w[1]   = (iv_weight_network == '0) ? (WEIGHT_W+1)'(1) : {1'b0, iv_weight_network};
    state_d    = state_q;
    credit_d   = credit_q;
    desc_d     = desc_q;
    dwr_d      = 1'b0;
    pop        = '0;
    turn_end   = 1'b0;
    cur        = (state_q == SERVE_NET);
    oth        = ~cur;
    credit_inc = {1'b0, credit_q} + (WEIGHT_W+1)'(1);
    case (state_q)
      IDLE: begin
        credit_d = '0;
        if (!empty[1])      state_d = SERVE_NET;
        else if (!empty[0]) state_d = SERVE_HCP;
      end
      SERVE_HCP, SERVE_NET: begin
        if (i_descriptor_ready) begin
          if (!empty[cur]) begin
            pop[cur] = 1'b1;
            desc_d   = mem_q[cur][rd_ptr_q[cur]];
            dwr_d    = 1'b1;
            credit_d = credit_inc[WEIGHT_W-1:0];
            // >= keeps the turn bounded if the weight drops mid-turn
            turn_end = (credit_inc >= eff_w[cur]);
          end else begin
            turn_end = 1'b1;
          end
          if (turn_end) begin
            credit_d = '0;
            if (!empty[oth])      state_d = oth ? SERVE_NET : SERVE_HCP;
            else if (!empty[cur]) state_d = state_q;
            else                  state_d = IDLE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_d[s][i] = mem_q[s][i];
      if (push[s]) mem_d[s][wr_ptr_q[s]] = in_desc[s];
      wr_ptr_d[s] = wr_ptr_q[s] + AW'(push[s]);
      rd_ptr_d[s] = rd_ptr_q[s] + AW'(pop[s]);
      case ({push[s], pop[s]})
        2'b10:   cnt_d[s] = cnt_q[s] + (AW+1)'(1);
        2'b01:   cnt_d[s] = cnt_q[s] - (AW+1)'(1);
        default: cnt_d[s] = cnt_q[s];
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      desc_q   <= '0;
      dwr_q    <= 1'b0;
      ack_q    <= '0;
      for (int s = 0; s < 2; s++) begin
        cnt_q[s]    <= '0;
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
      end
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      desc_q   <= desc_d;
      dwr_q    <= dwr_d;
      ack_q    <= ack_d;
      for (int s = 0; s < 2; s++) begin
        cnt_q[s]    <= cnt_d[s];
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
        for (int i = 0; i < FIFO_DEPTH; i++) mem_q[s][i] <= mem_d[s][i];
      end
    end
  end

  assign o_descriptor_ack_hcp     = ack_q[0];
  assign o_descriptor_ack_network = ack_q[1];
  assign ov_descriptor            = desc_q;
  assign o_descriptor_wr          = dwr_q;
  assign ov_arb_state             = state_q;

`ifdef TX_ARB_STATS_EN
  logic [15:0] gcnt_q [2], gcnt_d [2];
  logic [1:0]  fpulse_q, fpulse_d;

  always_comb begin
    fpulse_d = '0;
    for (int s = 0; s < 2; s++) begin
      gcnt_d[s]   = gcnt_q[s] + 16'(pop[s]);
      fpulse_d[s] = req[s] & full[s] & ~ack_q[s];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gcnt_q[0] <= '0;
      gcnt_q[1] <= '0;
      fpulse_q  <= '0;
    end else begin
      gcnt_q[0] <= gcnt_d[0];
      gcnt_q[1] <= gcnt_d[1];
      fpulse_q  <= fpulse_d;
    end
  end

  assign ov_grant_cnt_hcp          = gcnt_q[0];
  assign ov_grant_cnt_network      = gcnt_q[1];
  assign o_fifo_full_pulse_hcp     = fpulse_q[0];
  assign o_fifo_full_pulse_network = fpulse_q[1];
`endif

endmodule

// File: tb/tb_host_tx_descriptor_arbiter.sv
// Self-checking bench for host_tx_descriptor_arbiter: directed latency, FIFO-full,
// reset and table-driven weighted round-robin scenarios.
module tb_host_tx_descriptor_arbiter;

  logic        clk, rst;
  logic [47:0] tag_h, tag_n;
  logic [8:0]  buf_h, buf_n;
  logic        flag_h, flag_n, wr_h, wr_n, ack_h, ack_n;
  logic [3:0]  w_h, w_n;
  logic [23:0] desc;
  logic        dwr, ready;
  logic [1:0]  st;

  int chk_cnt = 0, pass_cnt = 0;
  int done_h = 0, done_n = 0, target_h = 0, target_n = 0;
  int grant_h = 0, grant_n = 0, strobes = 0;
  bit order_en = 0;
  logic [23:0] exp_h_q[$];
  logic [23:0] exp_n_q[$];

  typedef struct {
    int w_h; int w_n; int n; int exp_h; int exp_n;
  } wrr_vec_t;
  wrr_vec_t vecs[5];

  host_tx_descriptor_arbiter #(.FIFO_DEPTH(4), .WEIGHT_W(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .iv_tsntag_hcp(tag_h), .iv_bufid_hcp(buf_h),
    .i_inverse_map_lookup_flag_hcp(flag_h), .i_descriptor_wr_hcp(wr_h),
    .o_descriptor_ack_hcp(ack_h),
    .iv_tsntag_network(tag_n), .iv_bufid_network(buf_n),
    .i_inverse_map_lookup_flag_network(flag_n), .i_descriptor_wr_network(wr_n),
    .o_descriptor_ack_network(ack_n),
    .iv_weight_hcp(w_h), .iv_weight_network(w_n),
    .ov_descriptor(desc), .o_descriptor_wr(dwr),
    .i_descriptor_ready(ready), .ov_arb_state(st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Request k of a source: bufid[8] marks the source, low bits a sequence number.
  function automatic logic [23:0] mk_desc(input logic src, input int k);
    logic [13:0] flow;
    logic [8:0]  b;
    logic        f;
    if (!src) begin
      flow = 14'h1234 + 14'(k * 257);
      b    = {1'b0, 8'(k + 5)};
      f    = ~k[0];
    end else begin
      flow = 14'h2000 + 14'(k * 3);
      b    = {1'b1, 8'(k)};
      f    = k[0];
    end
    return {f, flow, b};
  endfunction

  function automatic int eff(input logic [3:0] w);
    return (w == 4'd0) ? 1 : int'(w);
  endfunction

  // Requester drivers and output scoreboard, all on the falling edge.
  initial begin : bench_io
    logic        src, exp_src, prev_en;
    logic [23:0] e, d;
    int          credit;
    exp_src = 1'b1; credit = 0; prev_en = 1'b0;
    wr_h = 0; wr_n = 0; tag_h = '0; tag_n = '0; buf_h = '0; buf_n = '0;
    flag_h = 0; flag_n = 0;
    forever begin
      @(negedge clk);
      if (dwr) begin
        src = desc[8];
        if (src) begin
          if (exp_n_q.size() == 0) chk("net_desc_expected", 0, 1);
          else begin e = exp_n_q.pop_front(); chk("net_desc", desc, e); end
          grant_n++;
        end else begin
          if (exp_h_q.size() == 0) chk("hcp_desc_expected", 0, 1);
          else begin e = exp_h_q.pop_front(); chk("hcp_desc", desc, e); end
          grant_h++;
        end
        if (order_en) begin
          chk("grant_src", src, exp_src);
          credit++;
          if (credit >= eff(exp_src ? w_n : w_h)) begin
            exp_src = ~exp_src;
            credit  = 0;
          end
        end
        strobes++;
      end
      if (ack_h) begin exp_h_q.push_back(mk_desc(1'b0, done_h)); done_h++; end
      if (ack_n) begin exp_n_q.push_back(mk_desc(1'b1, done_n)); done_n++; end
      if (rst) begin exp_h_q.delete(); exp_n_q.delete(); end
      if (order_en && !prev_en) begin exp_src = 1'b1; credit = 0; end
      prev_en = order_en;
      d = mk_desc(1'b0, done_h);
      wr_h = (done_h < target_h); flag_h = d[23]; buf_h = d[8:0];
      tag_h = {d[22:9], 34'(done_h * 13 + 7)};
      d = mk_desc(1'b1, done_n);
      wr_n = (done_n < target_n); flag_n = d[23]; buf_n = d[8:0];
      tag_n = {d[22:9], 34'(done_n * 11 + 3)};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    ready = 1'b1;
    while (n < 300 && !(exp_h_q.size() == 0 && exp_n_q.size() == 0 && !wr_h && !wr_n && st == 2'd0)) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, (n < 300), 1);
    chk({tag, "_idle"}, st, 0);
  endtask

  initial begin : main
    int base, sb, gh0, gn0, n;
    vecs[0] = '{3, 1, 400, 300, 100};
    vecs[1] = '{0, 0, 40, 20, 20};
    vecs[2] = '{2, 3, 50, 20, 30};
    vecs[3] = '{5, 2, 42, 30, 12};
    vecs[4] = '{0, 4, 40, 8, 32};

    rst = 1'b1; ready = 1'b0; w_h = 4'd1; w_n = 4'd1;
    repeat (2) tick();
    chk("rst_desc", desc, 0);
    chk("rst_wr", dwr, 0);
    chk("rst_ack_hcp", ack_h, 0);
    chk("rst_ack_net", ack_n, 0);
    chk("rst_state", st, 0);
    rst = 1'b0;
    tick();

    // Single HCP request: ack after capture, strobe three cycles after request.
    ready = 1'b1;
    target_h = 1;
    tick();
    chk("lat_ack", ack_h, 1);
    tick();
    chk("lat_ack_one_cycle", ack_h, 0);
    chk("lat_no_early_wr", dwr, 0);
    tick();
    chk("lat_wr", dwr, 1);
    chk("lat_desc", desc, 24'hA46805);
    tick();
    chk("lat_wr_pulse", dwr, 0);
    chk("lat_desc_hold", desc, 24'hA46805);
    wait_drain("lat");

    // FIFO full: four accepted, the fifth held until space frees.
    base = done_h;
    ready = 1'b0;
    target_h = base + 5;
    repeat (15) tick();
    chk("full_acks", done_h - base, 4);
    chk("full_req_held", wr_h, 1);
    n = 0;
    repeat (4) begin tick(); n += int'(ack_h); end
    chk("full_no_ack", n, 0);
    ready = 1'b1;
    n = 0;
    while (n < 50 && done_h != base + 5) begin tick(); n++; end
    chk("full_fifth_acked", done_h - base, 5);
    wait_drain("full");

    // Weighted round-robin with both sources backlogged.
    for (int r = 0; r < 5; r++) begin
      w_h = 4'(vecs[r].w_h);
      w_n = 4'(vecs[r].w_n);
      gh0 = grant_h; gn0 = grant_n;
      ready = 1'b0;
      order_en = 1'b1;
      target_h = done_h + 100000;
      target_n = done_n + 100000;
      repeat (16) tick();
      for (int c = 0; c < vecs[r].n * 4 + 40; c++) begin
        if (c % 4 == 0) begin
          if ((grant_h - gh0) + (grant_n - gn0) >= vecs[r].n) break;
          ready = 1'b1;
        end else begin
          ready = 1'b0;
        end
        tick();
      end
      ready = 1'b0;
      order_en = 1'b0;
      target_h = done_h;
      target_n = done_n;
      chk($sformatf("wrr%0d_hcp_grants", r), grant_h - gh0, vecs[r].exp_h);
      chk($sformatf("wrr%0d_net_grants", r), grant_n - gn0, vecs[r].exp_n);
      tick();
      wait_drain($sformatf("wrr%0d", r));
    end

    // Reset with three descriptors buffered: nothing stale afterwards.
    w_h = 4'd2; w_n = 4'd2;
    ready = 1'b0;
    base = done_h;
    target_h = base + 3;
    n = 0;
    while (n < 40 && done_h != base + 3) begin tick(); n++; end
    chk("rst3_buffered", done_h - base, 3);
    tick();
    rst = 1'b1;
    tick();
    chk("rst3_desc", desc, 0);
    chk("rst3_wr", dwr, 0);
    chk("rst3_ack_hcp", ack_h, 0);
    chk("rst3_ack_net", ack_n, 0);
    chk("rst3_state", st, 0);
    rst = 1'b0;
    sb = strobes;
    ready = 1'b1;
    repeat (12) tick();
    chk("rst3_no_stale", strobes - sb, 0);
    chk("rst3_idle", st, 0);

    // Request pending behind a full FIFO survives reset and is re-accepted.
    ready = 1'b0;
    base = done_h;
    target_h = base + 5;
    repeat (15) tick();
    chk("rstp_buffered", done_h - base, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb = strobes;
    ready = 1'b1;
    n = 0;
    while (n < 40 && done_h != base + 5) begin tick(); n++; end
    chk("rstp_reaccepted", done_h - base, 5);
    wait_drain("rstp");
    chk("rstp_strobes", strobes - sb, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
